// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive loader.
// Holds the FSM encoding and width helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int HALF = DEF_CLKS_PER_BIT / 2;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running cycle counter with clear and a terminal-count tick.
// Wraps to zero on the tick so periods chain without gaps.
module uart_bit_timer #(
  parameter int W    = 4,
  parameter int TERM = 16
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_clr,
  output logic out_tick
);

  localparam logic [W-1:0] LAST = W'(TERM - 1);

  logic [W-1:0] cnt;

  assign out_tick = (cnt == LAST);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      cnt <= '0;
    end else if (in_clr || out_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_loader.sv
// UART receiver feeding a register: one write strobe per good frame,
// one error strobe per bad stop bit, busy while a frame is in flight.
module uart_rx_loader
  import uart_rx_pkg::*;
#(
  parameter int SIZE         = 8,
  parameter int CLKS_PER_BIT = 2 * HALF
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_rx,
  output logic [SIZE-1:0] out_val,
  output logic            out_write,
  output logic            out_frame_err,
  output logic            out_busy
);

  localparam int CW       = clog2(CLKS_PER_BIT);
  localparam int BW       = clog2(SIZE + 1);
  localparam int HALF_CYC = CLKS_PER_BIT / 2;
  localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

  logic            rx_m;
  logic            rx_s;
  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [SIZE-1:0] shreg;
  logic            half_tick;
  logic            bit_tick;
  logic            half_clr;
  logic            bit_clr;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= in_rx;
      rx_s <= rx_m;
    end
  end

  // Bit timer restarts at the start-bit centre so data samples land mid-bit.
  assign half_clr = (state == ST_IDLE);
  assign bit_clr  = (state == ST_IDLE)
                 || (state == ST_START && half_tick);

  uart_bit_timer #(
    .W    (CW),
    .TERM (HALF_CYC)
  ) u_half (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_clr   (half_clr),
    .out_tick (half_tick)
  );

  uart_bit_timer #(
    .W    (CW),
    .TERM (CLKS_PER_BIT)
  ) u_bit (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_clr   (bit_clr),
    .out_tick (bit_tick)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      out_val       <= '0;
      out_write     <= 1'b0;
      out_frame_err <= 1'b0;
      out_busy      <= 1'b0;
    end else begin
      out_write     <= 1'b0;
      out_frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            out_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (half_tick) begin
            if (rx_s) begin
              state    <= ST_IDLE;
              out_busy <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            shreg   <= {rx_s, shreg[SIZE-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            if (rx_s) begin
              out_val   <= shreg;
              out_write <= 1'b1;
              out_busy  <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              out_frame_err <= 1'b1;
              state         <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state    <= ST_IDLE;
            out_busy <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Self-checking bench: frame-level timing model plus per-cycle compare.
// Directed scenarios first, then randomized frames, gaps and glitches.
module tb_uart_rx_loader;

  localparam int SIZE = 8;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int EVT  = HALF + CPB * (SIZE + 1);
  localparam int NCYC = 20000;

  logic            in_clk = 1'b0;
  logic            in_rst = 1'b1;
  logic            in_rx  = 1'b1;
  logic [SIZE-1:0] out_val;
  logic            out_write;
  logic            out_frame_err;
  logic            out_busy;

  uart_rx_loader #(
    .SIZE         (SIZE),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_rx         (in_rx),
    .out_val       (out_val),
    .out_write     (out_write),
    .out_frame_err (out_frame_err),
    .out_busy      (out_busy)
  );

  always #5 in_clk = ~in_clk;

  logic [7:0] reg_q;
  always @(posedge in_clk or posedge in_rst) begin
    if (in_rst) reg_q <= 8'h00;
    else if (out_write) reg_q <= out_val;
  end

  int cyc = 0;
  always @(posedge in_clk) cyc = cyc + 1;

  bit       exp_write [NCYC];
  bit       exp_err   [NCYC];
  bit       exp_busy  [NCYC];
  bit [7:0] exp_data  [NCYC];
  bit [7:0] mval = 8'h00;

  int n_chk = 0;
  int n_pass = 0;
  int wq[$];
  int n_wr = 0;
  int n_err = 0;
  int busy_fall = 0;
  bit prev_busy = 1'b0;
  bit prev_wr = 1'b0;
  logic [7:0] reg_after = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  always @(negedge in_clk) begin
    if (in_rst) mval = 8'h00;
    else if (cyc < NCYC && exp_write[cyc]) mval = exp_data[cyc];
    if (cyc < NCYC) begin
      chk("write", out_write, in_rst ? 1'b0 : exp_write[cyc]);
      chk("frame_err", out_frame_err, in_rst ? 1'b0 : exp_err[cyc]);
      chk("busy", out_busy, in_rst ? 1'b0 : exp_busy[cyc]);
      chk("val", out_val, mval);
    end
    if (prev_wr) reg_after = reg_q;
    prev_wr = out_write;
    if (out_write) begin
      wq.push_back(cyc);
      n_wr = n_wr + 1;
    end
    if (out_frame_err) n_err = n_err + 1;
    if (prev_busy && !out_busy) busy_fall = cyc;
    prev_busy = out_busy;
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic set_busy(input int a, input int b);
    for (int t = a; t <= b; t++) if (t < NCYC) exp_busy[t] = 1'b1;
  endtask

  // Pin falls just after edge p; the FSM sees it three edges later.
  task automatic send_frame(input logic [7:0] d, input bit stop,
                            input int extra_low);
    int p;
    int dd;
    int ev;
    int r;
    p  = cyc;
    dd = p + 3;
    ev = dd + EVT;
    r  = p + CPB * (SIZE + 2) + extra_low;
    if (ev < NCYC) begin
      if (stop) begin
        exp_write[ev] = 1'b1;
        exp_data[ev]  = d;
        set_busy(dd, ev - 1);
      end else begin
        exp_err[ev] = 1'b1;
        set_busy(dd, r + 2);
      end
    end
    in_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < SIZE; i++) begin
      in_rx = d[i];
      repeat (CPB) tick();
    end
    in_rx = stop;
    repeat (CPB) tick();
    if (!stop) begin
      repeat (extra_low) tick();
      in_rx = 1'b1;
    end
  endtask

  task automatic false_start(input int k);
    int dd;
    dd = cyc + 3;
    set_busy(dd, dd + HALF - 1);
    in_rx = 1'b0;
    repeat (k) tick();
    in_rx = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    int p;
    int n0;
    int e0;
    int dd;
    int kind;
    int gap;
    bit prev_err;

    in_rst = 1'b1;
    in_rx  = 1'b1;
    repeat (3) tick();
    chk("rst_val", out_val, 8'h00);
    chk("rst_busy", out_busy, 1'b0);
    chk("rst_write", out_write, 1'b0);
    in_rst = 1'b0;
    idle(5);

    n0 = n_wr;
    p  = cyc;
    send_frame(8'hA5, 1'b1, 0);
    idle(4);
    chk("a5_val", out_val, 8'hA5);
    chk("a5_model", mval, 8'hA5);
    chk("a5_pulses", n_wr - n0, 1);
    chk("a5_time", wq[$] - p, 155);
    chk("a5_err", n_err, 0);

    n0 = n_wr;
    p  = cyc;
    false_start(4);
    chk("fs_idle_time", busy_fall - p, 11);
    chk("fs_no_write", n_wr - n0, 0);
    chk("fs_no_err", n_err, 0);

    e0 = n_err;
    p  = cyc;
    send_frame(8'h3C, 1'b0, 40);
    chk("fe_busy_held", out_busy, 1'b1);
    idle(6);
    chk("fe_pulses", n_err - e0, 1);
    chk("fe_val_kept", out_val, 8'hA5);
    chk("fe_busy_fall", busy_fall - p, 203);

    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    idle(4);
    chk("b2b_spacing", wq[$] - wq[$-1], 160);
    chk("b2b_val", out_val, 8'hFF);

    p  = cyc;
    dd = p + 3;
    set_busy(dd, p + 71);
    in_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 3; i++) begin
      in_rx = (8'h5A >> i) & 8'h01;
      repeat (CPB) tick();
    end
    in_rx = 1'b1;
    repeat (HALF) tick();
    n0 = n_wr;
    in_rst = 1'b1;
    #1;
    chk("mid_rst_val", out_val, 8'h00);
    chk("mid_rst_busy", out_busy, 1'b0);
    chk("mid_rst_write", out_write, 1'b0);
    repeat (3) tick();
    in_rst = 1'b0;
    idle(5);
    chk("mid_rst_no_write", n_wr - n0, 0);
    send_frame(8'h81, 1'b1, 0);
    idle(4);
    chk("after_rst_val", out_val, 8'h81);

    send_frame(8'h7E, 1'b1, 0);
    idle(4);
    chk("chain_reg", reg_after, 8'h7E);

    prev_err = 1'b0;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      gap  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 25);
      if (prev_err && gap < 4) gap = 4;
      idle(gap);
      prev_err = 1'b0;
      if (kind <= 5) begin
        send_frame(8'($urandom), 1'b1, 0);
      end else if (kind <= 7) begin
        send_frame(8'($urandom), 1'b0, $urandom_range(0, 30));
        prev_err = 1'b1;
      end else begin
        false_start($urandom_range(1, 7));
      end
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
